// File: rtl/chunk_tail_if.sv
// rtl/chunk_tail_if.sv - handshake bundle between the read pipeline tail and chunk_tail
//
// Purpose: groups the three rdy/ack channels of chunk_tail.
//   chunk channel : i_chunk_rdy/i_chunk_ack carrying (i_beg, i_end)
//   beat channel  : i_mofs_rdy/i_mofs_ack carrying (i_mofs, i_id)
//   done channel  : o_done_rdy/o_done_ack carrying (o_mofs_last, o_count, o_err)
// Modports:
//   slave  - the chunk_tail side (consumes chunks/beats, produces done)
//   master - the environment side (produces chunks/beats, consumes done)
interface chunk_tail_if #(
  parameter int WBW    = 16,
  parameter int N_ICFG = 8,
  parameter int DIM    = 2
);
  localparam int ICFG_BW = $clog2(N_ICFG + 1);

  logic                          i_chunk_rdy;
  logic                          i_chunk_ack;
  logic [ICFG_BW-1:0]            i_beg;
  logic [ICFG_BW-1:0]            i_end;

  logic                          i_mofs_rdy;
  logic                          i_mofs_ack;
  logic [DIM-1:0][WBW-1:0]       i_mofs;
  logic [ICFG_BW-1:0]            i_id;

  logic                          o_done_rdy;
  logic                          o_done_ack;
  logic [DIM-1:0][WBW-1:0]       o_mofs_last;
  logic [ICFG_BW-1:0]            o_count;
  logic                          o_err;

  modport slave (
    input  i_chunk_rdy, i_beg, i_end,
    input  i_mofs_rdy, i_mofs, i_id,
    input  o_done_ack,
    output i_chunk_ack, i_mofs_ack,
    output o_done_rdy, o_mofs_last, o_count, o_err
  );

  modport master (
    output i_chunk_rdy, i_beg, i_end,
    output i_mofs_rdy, i_mofs, i_id,
    output o_done_ack,
    input  i_chunk_ack, i_mofs_ack,
    input  o_done_rdy, o_mofs_last, o_count, o_err
  );
endinterface

// File: rtl/chunk_tail.sv
// rtl/chunk_tail.sv - retires chunks of in-order config-id beats with one completion handshake
//
// Purpose: queues (beg, end) chunk bounds, consumes one offset beat per id in
// [beg, end) for the head chunk, flags any id that arrives out of order, and
// reports the chunk as complete on the done channel.
// Ports:
//   i_clk  - clock
//   i_rst  - asynchronous active-high reset
//   bus    - chunk_tail_if.slave (chunk, beat and done rdy/ack channels)
module chunk_tail #(
  parameter int WBW    = 16,
  parameter int N_ICFG = 8,
  parameter int DIM    = 2,
  parameter int CDEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  chunk_tail_if.slave bus
);
  localparam int ICFG_BW = $clog2(N_ICFG + 1);
  localparam int AW      = $clog2(CDEPTH);
  localparam logic [AW:0]        OCC_FULL = (AW+1)'(CDEPTH);
  localparam logic [AW:0]        OCC_ONE  = (AW+1)'(1);
  localparam logic [ICFG_BW-1:0] ID_ONE   = ICFG_BW'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COLLECT, S_DONE} state_t;

  state_t state, state_nxt;

  // chunk bounds queue
  logic [ICFG_BW-1:0] q_beg [CDEPTH];
  logic [ICFG_BW-1:0] q_end [CDEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        occ;
  logic               full, empty, push, pop;
  logic [ICFG_BW-1:0] head_beg, head_end;

  // per-chunk tracking
  logic [ICFG_BW-1:0]      exp_id;
  logic [ICFG_BW-1:0]      count_q;
  logic                    err_q;
  logic [DIM-1:0][WBW-1:0] mofs_last_q;

  logic mofs_ack, done_rdy, beat, last_beat;

  assign full     = (occ == OCC_FULL);
  assign empty    = (occ == '0);
  // full blocks a push even when the head is being popped this cycle
  assign push     = bus.i_chunk_rdy && !full;
  assign pop      = (state == S_DONE) && bus.o_done_ack;
  assign head_beg = q_beg[rd_ptr];
  assign head_end = q_end[rd_ptr];

  assign beat      = mofs_ack;
  assign last_beat = beat && ((exp_id + ID_ONE) == head_end);

  assign bus.i_chunk_ack = push;
  assign bus.i_mofs_ack  = mofs_ack;
  assign bus.o_done_rdy  = done_rdy;
  assign bus.o_mofs_last = mofs_last_q;
  assign bus.o_count     = count_q;
  assign bus.o_err       = err_q;

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      // a push into the empty queue starts LOAD on the very next cycle
      S_IDLE:    if (push || !empty) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = (head_beg == head_end) ? S_DONE : S_COLLECT;
      S_COLLECT: if (last_beat) state_nxt = S_DONE;
      S_DONE:    if (pop) state_nxt = (occ != OCC_ONE || push) ? S_LOAD : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    mofs_ack = 1'b0;
    done_rdy = 1'b0;
    case (state)
      S_COLLECT: mofs_ack = bus.i_mofs_rdy;
      S_DONE:    done_rdy = 1'b1;
      default:   ;
    endcase
  end

  // queue pointers and occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // queue storage; contents are only read behind a valid occupancy
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_beg[wr_ptr] <= bus.i_beg;
      q_end[wr_ptr] <= bus.i_end;
    end
  end

  // per-chunk tracking; mofs_last is kept across LOAD so it only changes on a beat
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      exp_id      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      mofs_last_q <= '0;
    end else if (state == S_LOAD) begin
      exp_id  <= head_beg;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (beat) begin
      // a wrong id is recorded but the beat is still consumed and counted
      err_q       <= err_q | (bus.i_id != exp_id);
      mofs_last_q <= bus.i_mofs;
      count_q     <= count_q + ID_ONE;
      exp_id      <= exp_id + ID_ONE;
    end
  end
endmodule

// File: tb/tb_chunk_tail.sv
// tb/tb_chunk_tail.sv - directed self-checking bench for chunk_tail
module tb_chunk_tail;
  localparam int WBW    = 16;
  localparam int N_ICFG = 8;
  localparam int DIM    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  chunk_tail_if #(.WBW(WBW), .N_ICFG(N_ICFG), .DIM(DIM)) bus ();

  chunk_tail #(.WBW(WBW), .N_ICFG(N_ICFG), .DIM(DIM), .CDEPTH(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_chunk_ack"}, 64'(bus.i_chunk_ack), 64'd0);
    chk({tag, "_mofs_ack"},  64'(bus.i_mofs_ack),  64'd0);
    chk({tag, "_done_rdy"},  64'(bus.o_done_rdy),  64'd0);
    chk({tag, "_mofs_last"}, 64'(bus.o_mofs_last), 64'd0);
    chk({tag, "_count"},     64'(bus.o_count),     64'd0);
    chk({tag, "_err"},       64'(bus.o_err),       64'd0);
  endtask

  task automatic push_chunk(input logic [3:0] b, input logic [3:0] e);
    bus.i_chunk_rdy = 1'b1;
    bus.i_beg = b;
    bus.i_end = e;
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] m);
    bus.i_mofs_rdy = 1'b1;
    bus.i_id   = id;
    bus.i_mofs = m;
  endtask

  initial begin
    bus.i_chunk_rdy = 1'b0;
    bus.i_beg       = '0;
    bus.i_end       = '0;
    bus.i_mofs_rdy  = 1'b0;
    bus.i_mofs      = '0;
    bus.i_id        = '0;
    bus.o_done_ack  = 1'b0;

    // reset state
    #2;
    chk_idle_outputs("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // single chunk beg=2 end=5, in-order beats
    push_chunk(4'd2, 4'd5); settle();
    chk("t1_chunk_ack", 64'(bus.i_chunk_ack), 64'd1);
    tick();
    bus.i_chunk_rdy = 1'b0;
    beat(4'd2, {16'd1, 16'd1}); settle();
    chk("t1_load_no_ack", 64'(bus.i_mofs_ack), 64'd0);
    tick();
    chk("t1_beat0_ack", 64'(bus.i_mofs_ack), 64'd1);
    tick();
    beat(4'd3, {16'd2, 16'd2}); settle();
    chk("t1_beat1_ack", 64'(bus.i_mofs_ack), 64'd1);
    tick();
    beat(4'd4, {16'd3, 16'd3}); settle();
    chk("t1_beat2_ack", 64'(bus.i_mofs_ack), 64'd1);
    chk("t1_not_done_yet", 64'(bus.o_done_rdy), 64'd0);
    tick();
    bus.i_mofs_rdy = 1'b0; settle();
    chk("t1_done_rdy", 64'(bus.o_done_rdy), 64'd1);
    chk("t1_count", 64'(bus.o_count), 64'd3);
    chk("t1_err", 64'(bus.o_err), 64'd0);
    chk("t1_mofs_last", 64'(bus.o_mofs_last), {32'd0, 16'd3, 16'd3});
    bus.o_done_ack = 1'b1;
    tick();
    bus.o_done_ack = 1'b0; settle();
    chk("t1_done_dropped", 64'(bus.o_done_rdy), 64'd0);
    chk("t1_count_held", 64'(bus.o_count), 64'd3);

    // out-of-order ids 0,2,1 within beg=0 end=3
    push_chunk(4'd0, 4'd3);
    tick();
    bus.i_chunk_rdy = 1'b0;
    beat(4'd0, {16'd5, 16'd0});
    tick();
    chk("t2_count_cleared", 64'(bus.o_count), 64'd0);
    tick();
    beat(4'd2, {16'd6, 16'd0});
    tick();
    beat(4'd1, {16'd7, 16'd0}); settle();
    chk("t2_third_ack", 64'(bus.i_mofs_ack), 64'd1);
    tick();
    bus.i_mofs_rdy = 1'b0; settle();
    chk("t2_done_rdy", 64'(bus.o_done_rdy), 64'd1);
    chk("t2_count", 64'(bus.o_count), 64'd3);
    chk("t2_err", 64'(bus.o_err), 64'd1);
    chk("t2_mofs_last", 64'(bus.o_mofs_last), {32'd0, 16'd7, 16'd0});
    bus.o_done_ack = 1'b1;
    tick();
    bus.o_done_ack = 1'b0;

    // zero-beat chunk beg=end=4, beats offered but never taken
    push_chunk(4'd4, 4'd4);
    beat(4'd4, {16'd8, 16'd8}); settle();
    chk("t3_chunk_ack", 64'(bus.i_chunk_ack), 64'd1);
    tick();
    bus.i_chunk_rdy = 1'b0; settle();
    chk("t3_load_done_rdy", 64'(bus.o_done_rdy), 64'd0);
    chk("t3_load_mofs_ack", 64'(bus.i_mofs_ack), 64'd0);
    tick();
    chk("t3_done_rdy", 64'(bus.o_done_rdy), 64'd1);
    chk("t3_count", 64'(bus.o_count), 64'd0);
    chk("t3_err", 64'(bus.o_err), 64'd0);

    // backpressure on done for 5 cycles, with the next chunk queued meanwhile
    push_chunk(4'd1, 4'd2); settle();
    chk("t4_push_while_done", 64'(bus.i_chunk_ack), 64'd1);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t4_mofs_ack_held", 64'(bus.i_mofs_ack), 64'd0);
      chk("t4_done_held", 64'(bus.o_done_rdy), 64'd1);
      chk("t4_count_held", 64'(bus.o_count), 64'd0);
      chk("t4_mofs_last_held", 64'(bus.o_mofs_last), {32'd0, 16'd7, 16'd0});
      tick();
      bus.i_chunk_rdy = 1'b0;
    end
    bus.o_done_ack = 1'b1;
    tick();
    bus.o_done_ack = 1'b0;
    beat(4'd1, {16'd9, 16'd9}); settle();
    chk("t4_next_load_done", 64'(bus.o_done_rdy), 64'd0);
    chk("t4_next_load_ack", 64'(bus.i_mofs_ack), 64'd0);
    tick();
    chk("t4_next_beat_ack", 64'(bus.i_mofs_ack), 64'd1);
    tick();
    bus.i_mofs_rdy = 1'b0; settle();
    chk("t4_next_done", 64'(bus.o_done_rdy), 64'd1);
    chk("t4_next_count", 64'(bus.o_count), 64'd1);
    chk("t4_next_mofs_last", 64'(bus.o_mofs_last), {32'd0, 16'd9, 16'd9});
    bus.o_done_ack = 1'b1;
    tick();
    bus.o_done_ack = 1'b0;

    // queue full: two zero-beat chunks queued, third waits through the pop cycle
    push_chunk(4'd0, 4'd0);
    tick();
    push_chunk(4'd3, 4'd3); settle();
    chk("t5_second_push", 64'(bus.i_chunk_ack), 64'd1);
    tick();
    push_chunk(4'd6, 4'd7); settle();
    chk("t5_full_block0", 64'(bus.i_chunk_ack), 64'd0);
    tick();
    chk("t5_full_block1", 64'(bus.i_chunk_ack), 64'd0);
    bus.o_done_ack = 1'b1; settle();
    chk("t5_full_pop_cycle", 64'(bus.i_chunk_ack), 64'd0);
    tick();
    bus.o_done_ack = 1'b0; settle();
    chk("t5_unblocked", 64'(bus.i_chunk_ack), 64'd1);
    tick();
    bus.i_chunk_rdy = 1'b0; settle();
    chk("t5_second_done", 64'(bus.o_done_rdy), 64'd1);
    chk("t5_second_count", 64'(bus.o_count), 64'd0);
    bus.o_done_ack = 1'b1;
    tick();
    bus.o_done_ack = 1'b0;
    beat(4'd6, {16'd4, 16'd4});
    tick();
    tick();
    bus.i_mofs_rdy = 1'b0; settle();
    chk("t5_third_done", 64'(bus.o_done_rdy), 64'd1);
    chk("t5_third_count", 64'(bus.o_count), 64'd1);
    chk("t5_third_mofs_last", 64'(bus.o_mofs_last), {32'd0, 16'd4, 16'd4});
    bus.o_done_ack = 1'b1;
    tick();
    bus.o_done_ack = 1'b0;

    // async reset after 1 of 3 beats, with a second chunk also queued
    push_chunk(4'd0, 4'd3);
    tick();
    push_chunk(4'd5, 4'd6);
    beat(4'd0, {16'd8, 16'd8});
    tick();
    bus.i_chunk_rdy = 1'b0;
    tick();
    bus.i_mofs_rdy = 1'b0; settle();
    chk("t6_one_beat", 64'(bus.o_count), 64'd1);
    bus.i_mofs_rdy = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk_idle_outputs("t6_reset");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t6_no_flushed_done", 64'(bus.o_done_rdy), 64'd0);
      chk("t6_no_beat_ack", 64'(bus.i_mofs_ack), 64'd0);
      tick();
    end
    push_chunk(4'd2, 4'd3);
    beat(4'd2, {16'd1, 16'd2});
    tick();
    bus.i_chunk_rdy = 1'b0;
    tick();
    tick();
    bus.i_mofs_rdy = 1'b0; settle();
    chk("t6_fresh_done", 64'(bus.o_done_rdy), 64'd1);
    chk("t6_fresh_count", 64'(bus.o_count), 64'd1);
    chk("t6_fresh_err", 64'(bus.o_err), 64'd0);
    chk("t6_fresh_mofs_last", 64'(bus.o_mofs_last), {32'd0, 16'd1, 16'd2});
    bus.o_done_ack = 1'b1;
    tick();
    bus.o_done_ack = 1'b0; settle();
    chk("t6_fresh_retired", 64'(bus.o_done_rdy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/chunk_tail.md
# chunk_tail

Receive-side counterpart of the chunk-head sequencer. The head expands one (bofs, aofs) chunk request into one memory-offset beat per config id in `[beg, end)`. This block consumes that beat stream at the far end, checks that ids arrive in order against the chunk bounds it was given, and retires the whole chunk with a single completion handshake. It sits at the tail of the read pipeline and lets the issuing side free a chunk slot once every id has drained.

## Interface
Parameters
- WBW, TauCfg::WORK_BW, width of one offset word
- N_ICFG, TauCfg::N_ICFG, number of config ids
- DIM, TauCfg::DIM, offset dimensions
- CDEPTH, 2, pending-chunk queue depth (power of two, ≥2)
- derived ICFG_BW = $clog2(N_ICFG+1)

Ports
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high
- i_chunk_rdy  in  1  chunk bounds valid
- i_chunk_ack  out  1  chunk bounds accepted
- i_beg  in  ICFG_BW  first id of chunk
- i_end  in  ICFG_BW  one past last id
- i_mofs_rdy  in  1  beat valid
- i_mofs_ack  out  1  beat accepted
- i_mofs  in  WBW×DIM  beat offsets
- i_id  in  ICFG_BW  beat config id
- o_done_rdy  out  1  chunk complete
- o_done_ack  in  1  completion taken
- o_mofs_last  out  WBW×DIM  offsets of last retired beat of chunk
- o_count  out  ICFG_BW  beats retired in chunk
- o_err  out  1  id mismatch seen in chunk

## Operation
- Handshake (rdyack): source raises rdy and holds it and its data stable until ack. ack is combinational, only asserted with rdy. Transfer occurs in the cycle ack=1.
- Chunk queue: CDEPTH-entry FIFO of (beg, end).
  - i_chunk_ack = i_chunk_rdy && !full.
  - A pop in the same cycle does not unblock a push when full.
- State machine on queue head:
  - IDLE: queue empty; all acks 0.
  - LOAD: one cycle. Loads exp_id=beg, count=0, err=0. If beg==end, go to DONE (zero-beat chunk), else COLLECT.
  - COLLECT: i_mofs_ack = i_mofs_rdy.
    - On each accepted beat: err |= (i_id != exp_id); o_mofs_last <= i_mofs; count++; exp_id++.
    - If exp_id+1 == end on that beat, go to DONE.
  - DONE: o_done_rdy=1; i_mofs_ack=0. On o_done_ack, pop the queue, then go to LOAD if the queue is still non-empty, else IDLE.
- o_count, o_err, o_mofs_last are registered. They are valid and stable while o_done_rdy=1, and hold their values after ack until the next LOAD.
- exp_id and the end compare are ICFG_BW wide. Wrap only occurs on an illegal beg>end: the count continues mod 2^ICFG_BW until equality.
- A mismatched id is still counted and consumed. It never stalls or terminates the chunk early.

## Timing
- Reset values:
  - outputs: i_chunk_ack=0 (comb, queue empty), i_mofs_ack=0, o_done_rdy=0, o_mofs_last=0, o_count=0, o_err=0.
  - internal: state IDLE, queue empty.
- Chunk pushed into an empty queue at cycle t: LOAD at t+1, first beat can be acked at t+2.
- Beats sustain 1 per cycle in COLLECT.
- Last beat acked at t: o_done_rdy=1 at t+1.
- o_done_ack at t with a queued next chunk: LOAD at t+1, COLLECT at t+2.
- i_chunk push and o_done pop may coincide; occupancy stays unchanged.
- Reset asserted mid-chunk: all state is cleared asynchronously and the queue is flushed. No o_done is produced for the flushed chunks.

## Test plan
- Single chunk beg=2, end=5; beats id 2,3,4 with mofs {1,1},{2,2},{3,3} back-to-back -> o_done_rdy one cycle after 3rd ack, o_count=3, o_err=0, o_mofs_last={3,3}.
- Out-of-order: beg=0, end=3, ids 0,2,1 -> three beats consumed, o_count=3, o_err=1.
- Zero-beat chunk beg=4, end=4 -> o_done_rdy two cycles after chunk ack, o_count=0; no i_mofs_ack asserted.
- Backpressure: hold o_done_ack=0 for 5 cycles with i_mofs_rdy=1 -> i_mofs_ack stays 0, outputs stable; ack -> next chunk loads.
- Queue full: push 2 chunks with no beats, 3rd chunk rdy -> i_chunk_ack=0 until first completion pops, including the pop cycle itself.
- Async reset asserted after 1 of 3 beats -> all outputs return to reset values immediately, queue empty, a fresh chunk completes normally.
